// File: rtl/branch_resolve_queue_pkg.sv
// Shared op-type constants: opcode ids, op-class codes and boolean levels.
// Latency: none (constants and a pure helper function only).
// Backpressure: not applicable.
package branch_resolve_queue_pkg;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  // Opcode ids as carried on enq_op / rob_op_commit
  localparam logic [5:0] OP_NOP  = 6'd0;
  localparam logic [5:0] OP_JAL  = 6'd1;
  localparam logic [5:0] OP_JALR = 6'd2;
  localparam logic [5:0] OP_BEQ  = 6'd3;
  localparam logic [5:0] OP_BNE  = 6'd4;
  localparam logic [5:0] OP_BLT  = 6'd5;
  localparam logic [5:0] OP_BGE  = 6'd6;
  localparam logic [5:0] OP_BLTU = 6'd7;
  localparam logic [5:0] OP_BGEU = 6'd8;

  // Op classes as carried on enq_op_type / rob_op_type
  localparam logic [2:0] OPT_RTYPE = 3'd0;
  localparam logic [2:0] OPT_ITYPE = 3'd1;
  localparam logic [2:0] OPT_STYPE = 3'd2;
  localparam logic [2:0] OPT_BTYPE = 3'd3;
  localparam logic [2:0] OPT_UTYPE = 3'd4;
  localparam logic [2:0] OPT_JTYPE = 3'd5;

  localparam logic [31:0] PC_STEP = 32'd4;

  // Fall-through PC; wraps at 2^32
  function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
    return pc + PC_STEP;
  endfunction

endpackage

// File: rtl/branch_resolve_queue_mispredict_check.sv
// Compares predicted vs actual outcome of one entry and computes its correct next PC.
// Latency: purely combinational.
// Backpressure: none; evaluated every cycle on the head entry.
module brq_mispredict_check
  import branch_resolve_queue_pkg::*;
(
  input  logic [31:0] i_pc,
  input  logic        i_pred_taken,
  input  logic [31:0] i_pred_target,
  input  logic        i_act_taken,
  input  logic [31:0] i_act_target,
  output logic        o_mispredict,
  output logic [31:0] o_next_pc
);

  // Wrong direction, or right "taken" direction with the wrong target
  always_comb begin
    o_next_pc    = i_act_taken ? i_act_target : pc_plus4(i_pc);
    o_mispredict = FALSE;
    if (i_pred_taken != i_act_taken) begin
      o_mispredict = TRUE;
    end else if (i_act_taken && (i_pred_target != i_act_target)) begin
      o_mispredict = TRUE;
    end
  end

endmodule

// File: rtl/branch_resolve_queue.sv
// In-order queue of in-flight branches: enqueue at dispatch, out-of-order resolve, in-order commit.
// Latency: commit outputs registered one cycle after the head is valid+resolved+commit_en_in.
// Backpressure: enq_ready low when full (no same-cycle bypass); rdy_in low freezes everything.
module branch_resolve_queue
  import branch_resolve_queue_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int TAG_W = 4
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             rdy_in,
  input  logic             flush_in,
  input  logic             enq_valid,
  input  logic [31:0]      enq_pc,
  input  logic [5:0]       enq_op,
  input  logic [2:0]       enq_op_type,
  input  logic             enq_pred_taken,
  input  logic [31:0]      enq_pred_target,
  output logic             enq_ready,
  output logic [TAG_W-1:0] enq_tag,
  input  logic             res_valid,
  input  logic [TAG_W-1:0] res_tag,
  input  logic             res_taken,
  input  logic [31:0]      res_target,
  input  logic             commit_en_in,
  output logic             rob_commit,
  output logic [31:0]      rob_pc_commit,
  output logic [5:0]       rob_op_commit,
  output logic [2:0]       rob_op_type,
  output logic             rob_result,
  output logic [31:0]      rob_pc_result,
  output logic             mispredict,
  output logic [TAG_W:0]   count
);

  localparam logic [TAG_W:0]   FULL_CNT = (TAG_W+1)'(DEPTH);
  localparam logic [TAG_W:0]   CNT_ONE  = (TAG_W+1)'(1);
  localparam logic [TAG_W-1:0] TAG_ONE  = TAG_W'(1);

  // Per-entry state; payload arrays are only meaningful where r_valid is set
  logic [DEPTH-1:0] r_valid;
  logic [DEPTH-1:0] r_resolved;
  logic [31:0]      r_pc          [DEPTH];
  logic [5:0]       r_op          [DEPTH];
  logic [2:0]       r_op_type     [DEPTH];
  logic             r_pred_taken  [DEPTH];
  logic [31:0]      r_pred_target [DEPTH];
  logic             r_act_taken   [DEPTH];
  logic [31:0]      r_act_target  [DEPTH];

  logic [TAG_W-1:0] r_head;
  logic [TAG_W-1:0] r_tail;
  logic [TAG_W:0]   r_count;

  logic             r_commit;
  logic             r_mispredict;
  logic [31:0]      r_pc_commit;
  logic [5:0]       r_op_commit;
  logic [2:0]       r_op_type_commit;
  logic             r_result;
  logic [31:0]      r_pc_result;

  logic             w_enq_fire;
  logic             w_res_fire;
  logic             w_commit_fire;
  logic             w_head_misp;
  logic [31:0]      w_head_next_pc;
  logic             w_squash;
  logic [TAG_W:0]   w_count_nxt;

  assign enq_ready = (r_count != FULL_CNT);
  assign enq_tag   = r_tail;
  assign count     = r_count;

  // Pulse outputs are masked while frozen; the rest simply hold their registers
  assign rob_commit    = r_commit & rdy_in;
  assign mispredict    = r_mispredict & rdy_in;
  assign rob_pc_commit = r_pc_commit;
  assign rob_op_commit = r_op_commit;
  assign rob_op_type   = r_op_type_commit;
  assign rob_result    = r_result;
  assign rob_pc_result = r_pc_result;

  assign w_enq_fire    = enq_valid && enq_ready;
  assign w_res_fire    = res_valid && r_valid[res_tag];
  // Uses registered resolved bit, so a same-cycle resolve of the head is not seen here
  assign w_commit_fire = !flush_in && r_valid[r_head] && r_resolved[r_head] && commit_en_in;
  assign w_squash      = flush_in || (w_commit_fire && w_head_misp);

  brq_mispredict_check u_misp_check (
    .i_pc          (r_pc[r_head]),
    .i_pred_taken  (r_pred_taken[r_head]),
    .i_pred_target (r_pred_target[r_head]),
    .i_act_taken   (r_act_taken[r_head]),
    .i_act_target  (r_act_target[r_head]),
    .o_mispredict  (w_head_misp),
    .o_next_pc     (w_head_next_pc)
  );

  // Occupancy: enqueue and commit together leave the count unchanged
  always_comb begin
    w_count_nxt = r_count;
    if (w_enq_fire && !w_commit_fire) begin
      w_count_nxt = r_count + CNT_ONE;
    end else if (!w_enq_fire && w_commit_fire) begin
      w_count_nxt = r_count - CNT_ONE;
    end
  end

  // Control state, pointers and commit-side outputs; squash wins over enqueue/resolve
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      r_head           <= '0;
      r_tail           <= '0;
      r_count          <= '0;
      r_valid          <= '0;
      r_resolved       <= '0;
      r_commit         <= 1'b0;
      r_mispredict     <= 1'b0;
      r_pc_commit      <= '0;
      r_op_commit      <= '0;
      r_op_type_commit <= '0;
      r_result         <= 1'b0;
      r_pc_result      <= '0;
    end else if (rdy_in) begin
      r_commit     <= w_commit_fire;
      r_mispredict <= w_commit_fire && w_head_misp;
      if (w_commit_fire) begin
        r_pc_commit      <= r_pc[r_head];
        r_op_commit      <= r_op[r_head];
        r_op_type_commit <= r_op_type[r_head];
        r_result         <= r_act_taken[r_head];
        r_pc_result      <= w_head_next_pc;
      end
      if (w_squash) begin
        r_head     <= '0;
        r_tail     <= '0;
        r_count    <= '0;
        r_valid    <= '0;
        r_resolved <= '0;
      end else begin
        if (w_enq_fire) begin
          r_valid[r_tail]    <= 1'b1;
          r_resolved[r_tail] <= 1'b0;
          r_tail             <= r_tail + TAG_ONE;
        end
        if (w_res_fire) begin
          r_resolved[res_tag] <= 1'b1;
        end
        // Retiring entry is cleared last so a late resolve to it cannot revive it
        if (w_commit_fire) begin
          r_valid[r_head]    <= 1'b0;
          r_resolved[r_head] <= 1'b0;
          r_head             <= r_head + TAG_ONE;
        end
        r_count <= w_count_nxt;
      end
    end else begin
      r_commit     <= 1'b0;
      r_mispredict <= 1'b0;
    end
  end

  // Entry payload: prediction at enqueue, actual outcome at resolve
  always_ff @(posedge clk_in) begin
    if (rst_n_in && rdy_in && !w_squash) begin
      if (w_enq_fire) begin
        r_pc[r_tail]          <= enq_pc;
        r_op[r_tail]          <= enq_op;
        r_op_type[r_tail]     <= enq_op_type;
        r_pred_taken[r_tail]  <= enq_pred_taken;
        r_pred_target[r_tail] <= enq_pred_target;
      end
      if (w_res_fire) begin
        r_act_taken[res_tag]  <= res_taken;
        r_act_target[res_tag] <= res_target;
      end
    end
  end

endmodule

// File: tb/tb_branch_resolve_queue.sv
// Directed bench for branch_resolve_queue with a commit scoreboard.
// Stimulus pushes hand-computed commit records; a negedge monitor pops and compares.
// Occupancy, tags and pulse timing are checked directly from the stimulus thread.
module tb_branch_resolve_queue;
  import branch_resolve_queue_pkg::*;

  localparam int DEPTH = 16;
  localparam int TAG_W = 4;

  logic             clk_in = 1'b0;
  logic             rst_n_in;
  logic             rdy_in;
  logic             flush_in;
  logic             enq_valid;
  logic [31:0]      enq_pc;
  logic [5:0]       enq_op;
  logic [2:0]       enq_op_type;
  logic             enq_pred_taken;
  logic [31:0]      enq_pred_target;
  logic             enq_ready;
  logic [TAG_W-1:0] enq_tag;
  logic             res_valid;
  logic [TAG_W-1:0] res_tag;
  logic             res_taken;
  logic [31:0]      res_target;
  logic             commit_en_in;
  logic             rob_commit;
  logic [31:0]      rob_pc_commit;
  logic [5:0]       rob_op_commit;
  logic [2:0]       rob_op_type;
  logic             rob_result;
  logic [31:0]      rob_pc_result;
  logic             mispredict;
  logic [TAG_W:0]   count;

  branch_resolve_queue #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in), .flush_in(flush_in),
    .enq_valid(enq_valid), .enq_pc(enq_pc), .enq_op(enq_op), .enq_op_type(enq_op_type),
    .enq_pred_taken(enq_pred_taken), .enq_pred_target(enq_pred_target),
    .enq_ready(enq_ready), .enq_tag(enq_tag),
    .res_valid(res_valid), .res_tag(res_tag), .res_taken(res_taken), .res_target(res_target),
    .commit_en_in(commit_en_in),
    .rob_commit(rob_commit), .rob_pc_commit(rob_pc_commit), .rob_op_commit(rob_op_commit),
    .rob_op_type(rob_op_type), .rob_result(rob_result), .rob_pc_result(rob_pc_result),
    .mispredict(mispredict), .count(count)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [31:0] pc;
    logic [5:0]  op;
    logic [2:0]  opt;
    logic        res;
    logic [31:0] npc;
    logic        misp;
  } exp_t;

  exp_t             sb[$];
  int               checks = 0;
  int               errors = 0;
  logic [TAG_W-1:0] exp_tail = '0;

  // Monitor: every commit pulse must match the oldest expected record
  always @(negedge clk_in) begin
    if (rob_commit) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_commit pc=0x%0h required no commit", rob_pc_commit);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (rob_pc_commit !== e.pc || rob_op_commit !== e.op || rob_op_type !== e.opt ||
            rob_result !== e.res || rob_pc_result !== e.npc || mispredict !== e.misp) begin
          errors++;
          $display("FAIL commit_record actual pc=0x%0h op=%0d opt=%0d res=%0b npc=0x%0h misp=%0b required pc=0x%0h op=%0d opt=%0d res=%0b npc=0x%0h misp=%0b",
                   rob_pc_commit, rob_op_commit, rob_op_type, rob_result, rob_pc_result, mispredict,
                   e.pc, e.op, e.opt, e.res, e.npc, e.misp);
        end
      end
    end else if (mispredict) begin
      checks++;
      errors++;
      $display("FAIL mispredict_without_commit actual=1 required=0");
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic push(input logic [31:0] pc, input logic [5:0] op, input logic [2:0] opt,
                      input logic res, input logic [31:0] npc, input logic misp);
    exp_t e;
    e.pc = pc; e.op = op; e.opt = opt; e.res = res; e.npc = npc; e.misp = misp;
    sb.push_back(e);
  endtask

  task automatic do_enq(input logic [31:0] pc, input logic [5:0] op, input logic [2:0] opt,
                        input logic pt, input logic [31:0] ptgt, output logic [TAG_W-1:0] tag);
    chk("enq_tag", 32'(enq_tag), 32'(exp_tail));
    tag             = exp_tail;
    enq_valid       = 1'b1;
    enq_pc          = pc;
    enq_op          = op;
    enq_op_type     = opt;
    enq_pred_taken  = pt;
    enq_pred_target = ptgt;
    tick();
    enq_valid = 1'b0;
    exp_tail  = exp_tail + 4'd1;
  endtask

  task automatic do_res(input logic [TAG_W-1:0] tag, input logic taken, input logic [31:0] tgt);
    res_valid  = 1'b1;
    res_tag    = tag;
    res_taken  = taken;
    res_target = tgt;
    tick();
    res_valid = 1'b0;
  endtask

  logic [TAG_W-1:0] t0, t1, t2, tx;
  logic [TAG_W-1:0] fill_tag [16];

  initial begin
    rst_n_in = 1'b0; rdy_in = 1'b1; flush_in = 1'b0; commit_en_in = 1'b1;
    enq_valid = 1'b0; enq_pc = '0; enq_op = '0; enq_op_type = '0;
    enq_pred_taken = 1'b0; enq_pred_target = '0;
    res_valid = 1'b0; res_tag = '0; res_taken = 1'b0; res_target = '0;
    tick(); tick();
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_enq_ready", 32'(enq_ready), 32'd1);
    chk("rst_enq_tag", 32'(enq_tag), 32'd0);
    chk("rst_rob_commit", 32'(rob_commit), 32'd0);
    chk("rst_pc_result", rob_pc_result, 32'd0);
    rst_n_in = 1'b1;
    tick();

    // Correctly predicted not-taken BEQ
    do_enq(32'h100, OP_BEQ, OPT_BTYPE, 1'b0, 32'h180, t0);
    chk("t1_count", 32'(count), 32'd1);
    push(32'h100, OP_BEQ, OPT_BTYPE, 1'b0, 32'h104, 1'b0);
    do_res(t0, 1'b0, 32'h0);
    tick(); tick();
    chk("t1_drain", 32'(sb.size()), 32'd0);
    chk("t1_count_after", 32'(count), 32'd0);

    // BNE predicted not-taken but taken: squash three younger, lose same-cycle enqueue
    do_enq(32'h200, OP_BNE, OPT_BTYPE, 1'b0, 32'h204, t0);
    do_enq(32'h204, OP_BEQ, OPT_BTYPE, 1'b0, 32'h0, t1);
    do_enq(32'h208, OP_BEQ, OPT_BTYPE, 1'b0, 32'h0, t2);
    do_enq(32'h20c, OP_BEQ, OPT_BTYPE, 1'b0, 32'h0, tx);
    chk("t2_count4", 32'(count), 32'd4);
    push(32'h200, OP_BNE, OPT_BTYPE, 1'b1, 32'h240, 1'b1);
    do_res(t0, 1'b1, 32'h240);
    enq_valid = 1'b1; enq_pc = 32'h210; enq_op = OP_BEQ; enq_op_type = OPT_BTYPE;
    tick();
    enq_valid = 1'b0;
    exp_tail  = '0;
    chk("t2_misp_pulse", 32'(mispredict), 32'd1);
    chk("t2_squash_count", 32'(count), 32'd0);
    chk("t2_squash_tag", 32'(enq_tag), 32'd0);
    do_res(t1, 1'b0, 32'h0);
    tick();
    chk("t2_squashed_no_commit", 32'(rob_commit), 32'd0);
    chk("t2_drain", 32'(sb.size()), 32'd0);

    // JALR wrong target, then the same JALR with the right target
    do_enq(32'h300, OP_JALR, OPT_ITYPE, 1'b1, 32'h400, t0);
    push(32'h300, OP_JALR, OPT_ITYPE, 1'b1, 32'h404, 1'b1);
    do_res(t0, 1'b1, 32'h404);
    tick();
    exp_tail = '0;
    chk("t3_squash_count", 32'(count), 32'd0);
    do_enq(32'h300, OP_JALR, OPT_ITYPE, 1'b1, 32'h400, t0);
    push(32'h300, OP_JALR, OPT_ITYPE, 1'b1, 32'h400, 1'b0);
    do_res(t0, 1'b1, 32'h400);
    tick(); tick();
    chk("t3_drain", 32'(sb.size()), 32'd0);
    chk("t3_enq_tag", 32'(enq_tag), 32'd1);

    // Out-of-order resolve, in-order commit on consecutive cycles
    do_enq(32'h500, OP_BEQ, OPT_BTYPE, 1'b0, 32'h0, t0);
    do_enq(32'h504, OP_BEQ, OPT_BTYPE, 1'b0, 32'h0, t1);
    do_enq(32'h508, OP_BEQ, OPT_BTYPE, 1'b0, 32'h0, t2);
    do_res(t2, 1'b0, 32'h0);
    chk("t4_no_early_a", 32'(rob_commit), 32'd0);
    do_res(t1, 1'b0, 32'h0);
    chk("t4_no_early_b", 32'(rob_commit), 32'd0);
    tick();
    chk("t4_no_early_c", 32'(rob_commit), 32'd0);
    push(32'h500, OP_BEQ, OPT_BTYPE, 1'b0, 32'h504, 1'b0);
    push(32'h504, OP_BEQ, OPT_BTYPE, 1'b0, 32'h508, 1'b0);
    push(32'h508, OP_BEQ, OPT_BTYPE, 1'b0, 32'h50c, 1'b0);
    do_res(t0, 1'b0, 32'h0);
    chk("t4_same_cycle_res_hidden", 32'(rob_commit), 32'd0);
    tick(); chk("t4_commit0", 32'(rob_commit), 32'd1);
    tick(); chk("t4_commit1", 32'(rob_commit), 32'd1);
    tick(); chk("t4_commit2", 32'(rob_commit), 32'd1);
    tick(); chk("t4_idle", 32'(rob_commit), 32'd0);
    chk("t4_drain", 32'(sb.size()), 32'd0);

    // Fill to full with tail wrap, drop 17th, commit, then commit+enqueue
    commit_en_in = 1'b0;
    for (int i = 0; i < 16; i++) begin
      do_enq(32'h1000 + 32'(i * 4), OP_BEQ, OPT_BTYPE, 1'b0, 32'h0, fill_tag[i]);
    end
    chk("t5_full_count", 32'(count), 32'd16);
    chk("t5_enq_ready", 32'(enq_ready), 32'd0);
    enq_valid = 1'b1; enq_pc = 32'h1fff0;
    tick();
    enq_valid = 1'b0;
    chk("t5_drop_count", 32'(count), 32'd16);
    chk("t5_drop_tag", 32'(enq_tag), 32'(exp_tail));
    push(32'h1000, OP_BEQ, OPT_BTYPE, 1'b0, 32'h1004, 1'b0);
    push(32'h1004, OP_BEQ, OPT_BTYPE, 1'b0, 32'h1008, 1'b0);
    do_res(fill_tag[0], 1'b0, 32'h0);
    do_res(fill_tag[1], 1'b0, 32'h0);
    commit_en_in = 1'b1;
    tick();
    chk("t5_after_commit", 32'(count), 32'd15);
    do_enq(32'h2000, OP_BEQ, OPT_BTYPE, 1'b0, 32'h0, tx);
    chk("t5_commit_plus_enq", 32'(count), 32'd15);
    commit_en_in = 1'b0;
    do_res(fill_tag[2], 1'b0, 32'h0);
    commit_en_in = 1'b1;
    flush_in = 1'b1;
    tick();
    flush_in = 1'b0;
    exp_tail = '0;
    chk("t5_flush_count", 32'(count), 32'd0);
    chk("t5_flush_tag", 32'(enq_tag), 32'd0);
    chk("t5_flush_no_commit", 32'(rob_commit), 32'd0);
    tick();
    chk("t5_drain", 32'(sb.size()), 32'd0);

    // rdy_in low freezes a resolved head and blocks enqueue
    do_enq(32'h600, OP_BEQ, OPT_BTYPE, 1'b0, 32'h0, t0);
    do_res(t0, 1'b0, 32'h0);
    rdy_in = 1'b0;
    enq_valid = 1'b1; enq_pc = 32'h700;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t6_frozen_commit", 32'(rob_commit), 32'd0);
      chk("t6_frozen_count", 32'(count), 32'd1);
    end
    chk("t6_frozen_tag", 32'(enq_tag), 32'(exp_tail));
    enq_valid = 1'b0;
    rdy_in = 1'b1;
    push(32'h600, OP_BEQ, OPT_BTYPE, 1'b0, 32'h604, 1'b0);
    tick();
    chk("t6_commit_after_rdy", 32'(rob_commit), 32'd1);
    chk("t6_count", 32'(count), 32'd0);
    tick();

    // Reset in the middle of activity
    do_enq(32'h800, OP_BEQ, OPT_BTYPE, 1'b0, 32'h0, t0);
    do_enq(32'h804, OP_BEQ, OPT_BTYPE, 1'b0, 32'h0, t1);
    enq_valid = 1'b1; enq_pc = 32'h808;
    res_valid = 1'b1; res_tag = t0; res_taken = 1'b0;
    rst_n_in = 1'b0;
    tick();
    enq_valid = 1'b0; res_valid = 1'b0;
    exp_tail = '0;
    chk("t7_rst_count", 32'(count), 32'd0);
    chk("t7_rst_enq_ready", 32'(enq_ready), 32'd1);
    chk("t7_rst_tag", 32'(enq_tag), 32'd0);
    chk("t7_rst_pc_result", rob_pc_result, 32'd0);
    chk("t7_rst_pc_commit", rob_pc_commit, 32'd0);
    rst_n_in = 1'b1;
    tick(); tick(); tick();
    chk("t7_idle_commit", 32'(rob_commit), 32'd0);
    chk("final_drain", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
